// File: rtl/damage_accumulator_pkg.sv
// damage_accumulator_pkg
// Shared definitions for the damage accumulator and the physics block:
// state encoding, damage clamp, knockback shift and default frame counts.
// No ports; imported with "import damage_accumulator_pkg::*".
package damage_accumulator_pkg;

  typedef enum logic [2:0] {
    ST_ARMED        = 3'd0,
    ST_HITSTUN      = 3'd1,
    ST_WAIT_RELEASE = 3'd2,
    ST_RESPAWN      = 3'd3,
    ST_DEAD         = 3'd4
  } state_e;

  localparam int CNT_W   = 16;
  localparam int STOCK_W = 3;
  localparam int KB_SHIFT = 3;

  localparam logic [7:0]       DMG_CLAMP          = 8'd255;
  localparam logic [CNT_W-1:0] DEF_HITSTUN_FRAMES = 16'd20;
  localparam logic [CNT_W-1:0] DEF_RESPAWN_FRAMES = 16'd120;

  // Saturate the raw 32-bit damage to 8 bits so upper bits never reach the math.
  function automatic logic [7:0] clamp_damage(input logic [31:0] d);
    logic [7:0] r;
    if (d > {24'd0, DMG_CLAMP}) begin
      r = DMG_CLAMP;
    end else begin
      r = d[7:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/damage_accumulator_if.sv
// damage_accumulator_if
// Bundles the coprocessor-facing inputs and the physics/HUD outputs.
//   damage[31:0], hit, ko, frame_tick       : toward the accumulator
//   percent[31:0], knockback[31:0], hit_pulse,
//   hitstun, stocks[2:0], game_over          : from the accumulator
// master: stimulus/upstream side; slave: the accumulator.
interface damage_accumulator_if;
  import damage_accumulator_pkg::*;

  logic [31:0]        damage;
  logic               hit;
  logic               ko;
  logic               frame_tick;
  logic [31:0]        percent;
  logic [31:0]        knockback;
  logic               hit_pulse;
  logic               hitstun;
  logic [STOCK_W-1:0] stocks;
  logic               game_over;

  modport master (
    output damage, hit, ko, frame_tick,
    input  percent, knockback, hit_pulse, hitstun, stocks, game_over
  );

  modport slave (
    input  damage, hit, ko, frame_tick,
    output percent, knockback, hit_pulse, hitstun, stocks, game_over
  );

endinterface

// File: rtl/damage_accumulator_frame_down_counter.sv
// frame_down_counter
// Loadable frame counter shared by the HITSTUN and RESPAWN windows.
//   clock, reset : clock and synchronous active-high reset
//   load         : load load_value this cycle (wins over tick)
//   load_value   : frame count to load
//   tick         : one-cycle frame pulse, decrements the count
//   done         : combinational; this tick takes the count from 1 to 0
module frame_down_counter
  import damage_accumulator_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         tick,
  output logic         done
);

  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] ZERO = {W{1'b0}};

  logic [W-1:0] count_r;

  // Count register: load has priority so a tick in the load cycle is not counted.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r <= ZERO;
    end else if (load) begin
      count_r <= load_value;
    end else if (tick && (count_r != ZERO)) begin
      count_r <= count_r - ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign done = tick & ~load & (count_r == ONE);

endmodule

// File: rtl/damage_accumulator.sv
// damage_accumulator
// Turns the coprocessor's level-type damage into single hit events, keeps a
// saturating percent, computes knockback, runs hitstun/respawn windows and
// tracks stocks / game over. All outputs are registered.
//   clock, reset : clock and synchronous active-high reset
//   bus (slave)  : damage, hit, ko, frame_tick in;
//                  percent, knockback, hit_pulse, hitstun, stocks, game_over out
module damage_accumulator
  import damage_accumulator_pkg::*;
#(
  parameter logic [31:0]        MAX_PERCENT    = 32'd999,
  parameter logic [CNT_W-1:0]   HITSTUN_FRAMES = DEF_HITSTUN_FRAMES,
  parameter logic [CNT_W-1:0]   RESPAWN_FRAMES = DEF_RESPAWN_FRAMES,
  parameter logic [STOCK_W-1:0] START_STOCKS   = 3'd3,
  parameter logic [31:0]        KB_BASE        = 32'd8
) (
  input  logic                 clock,
  input  logic                 reset,
  damage_accumulator_if.slave  bus
);

  state_e             state_r, next_state_s;
  logic [31:0]        percent_r, percent_n_s;
  logic [31:0]        knockback_r, knockback_n_s;
  logic               hit_pulse_r, hit_pulse_n_s;
  logic               hitstun_r;
  logic [STOCK_W-1:0] stocks_r, stocks_n_s;
  logic               game_over_r, game_over_n_s;

  logic               cnt_load_s;
  logic [CNT_W-1:0]   cnt_value_s;
  logic               cnt_done_s;

  logic [7:0]         dmg_c_s;
  logic [31:0]        p_sum_s;
  logic [31:0]        p_new_s;
  logic [63:0]        kb_prod_s;
  logic               accept_s;
  logic               ko_live_s;

  // percent never exceeds MAX_PERCENT, so the 32-bit sum cannot wrap.
  assign dmg_c_s   = clamp_damage(bus.damage);
  assign p_sum_s   = percent_r + {24'd0, dmg_c_s};
  assign p_new_s   = (p_sum_s > MAX_PERCENT) ? MAX_PERCENT : p_sum_s;
  assign kb_prod_s = 64'(p_new_s) * 64'(dmg_c_s);

  assign accept_s  = (state_r == ST_ARMED) & bus.hit & (bus.damage != 32'd0) & ~bus.ko;
  assign ko_live_s = bus.ko & ((state_r == ST_ARMED) | (state_r == ST_HITSTUN) |
                               (state_r == ST_WAIT_RELEASE));

  frame_down_counter #(.W(CNT_W)) u_frame_cnt (
    .clock      (clock),
    .reset      (reset),
    .load       (cnt_load_s),
    .load_value (cnt_value_s),
    .tick       (bus.frame_tick),
    .done       (cnt_done_s)
  );

  // Next-state and next-output logic; ko outranks every hit or timer event.
  always_comb begin
    next_state_s  = state_r;
    percent_n_s   = percent_r;
    knockback_n_s = knockback_r;
    hit_pulse_n_s = 1'b0;
    stocks_n_s    = stocks_r;
    game_over_n_s = game_over_r;
    cnt_load_s    = 1'b0;
    cnt_value_s   = HITSTUN_FRAMES;

    if (ko_live_s) begin
      stocks_n_s    = stocks_r - 3'd1;
      percent_n_s   = 32'd0;
      knockback_n_s = 32'd0;
      if (stocks_r == 3'd1) begin
        next_state_s  = ST_DEAD;
        game_over_n_s = 1'b1;
      end else begin
        next_state_s = ST_RESPAWN;
        cnt_load_s   = 1'b1;
        cnt_value_s  = RESPAWN_FRAMES;
      end
    end else begin
      case (state_r)
        ST_ARMED: begin
          if (accept_s) begin
            percent_n_s   = p_new_s;
            knockback_n_s = KB_BASE + 32'(kb_prod_s >> KB_SHIFT);
            hit_pulse_n_s = 1'b1;
            cnt_load_s    = 1'b1;
            cnt_value_s   = HITSTUN_FRAMES;
            next_state_s  = ST_HITSTUN;
          end else begin
            next_state_s = ST_ARMED;
          end
        end
        ST_HITSTUN: begin
          if (cnt_done_s) begin
            next_state_s = ST_WAIT_RELEASE;
          end else begin
            next_state_s = ST_HITSTUN;
          end
        end
        // Held attacks keep damage non-zero; wait for it to drop before re-arming.
        ST_WAIT_RELEASE: begin
          if (bus.damage == 32'd0) begin
            next_state_s = ST_ARMED;
          end else begin
            next_state_s = ST_WAIT_RELEASE;
          end
        end
        ST_RESPAWN: begin
          if (cnt_done_s) begin
            next_state_s = ST_ARMED;
          end else begin
            next_state_s = ST_RESPAWN;
          end
        end
        ST_DEAD: begin
          next_state_s = ST_DEAD;
        end
        default: begin
          next_state_s = ST_ARMED;
        end
      endcase
    end
  end

  // State and output registers; hitstun is decoded from the next state so it
  // lines up with the state it describes.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_ARMED;
      percent_r   <= 32'd0;
      knockback_r <= 32'd0;
      hit_pulse_r <= 1'b0;
      hitstun_r   <= 1'b0;
      stocks_r    <= START_STOCKS;
      game_over_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      percent_r   <= percent_n_s;
      knockback_r <= knockback_n_s;
      hit_pulse_r <= hit_pulse_n_s;
      hitstun_r   <= (next_state_s == ST_HITSTUN) | (next_state_s == ST_RESPAWN);
      stocks_r    <= stocks_n_s;
      game_over_r <= game_over_n_s;
    end
  end

  assign bus.percent   = percent_r;
  assign bus.knockback = knockback_r;
  assign bus.hit_pulse = hit_pulse_r;
  assign bus.hitstun   = hitstun_r;
  assign bus.stocks    = stocks_r;
  assign bus.game_over = game_over_r;

endmodule

// File: tb/tb_damage_accumulator.sv
// tb_damage_accumulator
// Self-checking bench: expected outputs are queued when a cycle's stimulus is
// driven and popped/compared one clock later, after the rising edge.
module tb_damage_accumulator;
  import damage_accumulator_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  damage_accumulator_if bus();

  damage_accumulator dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] p;
    logic [31:0] kb;
    logic        pulse;
    logic        hs;
    logic [2:0]  st;
    logic        go;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] d;
    logic        h;
    logic        k;
    logic        t;
    logic [31:0] p;
    logic [31:0] kb;
    logic        pulse;
    logic        hs;
    logic [2:0]  st;
    logic        go;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[5];
  int   checks = 0;
  int   errors = 0;

  task automatic drive(input logic [31:0] d, input logic h, input logic k, input logic t);
    bus.damage     = d;
    bus.hit        = h;
    bus.ko         = k;
    bus.frame_tick = t;
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [31:0] p, input logic [31:0] kb,
                            input logic pulse, input logic hs, input logic [2:0] st,
                            input logic go);
    exp_t e;
    e.name = name; e.p = p; e.kb = kb; e.pulse = pulse; e.hs = hs; e.st = st; e.go = go;
    sb_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expected record for this output");
    end else begin
      e = sb_q.pop_front();
      if (bus.percent !== e.p || bus.knockback !== e.kb || bus.hit_pulse !== e.pulse ||
          bus.hitstun !== e.hs || bus.stocks !== e.st || bus.game_over !== e.go) begin
        errors++;
        $display("FAIL %s: got percent=%0d knockback=%0d hit_pulse=%0b hitstun=%0b stocks=%0d game_over=%0b; want percent=%0d knockback=%0d hit_pulse=%0b hitstun=%0b stocks=%0d game_over=%0b",
                 e.name, bus.percent, bus.knockback, bus.hit_pulse, bus.hitstun, bus.stocks,
                 bus.game_over, e.p, e.kb, e.pulse, e.hs, e.st, e.go);
      end
    end
  endtask

  task automatic step(input string name, input logic [31:0] d, input logic h, input logic k,
                      input logic t, input logic [31:0] p, input logic [31:0] kb,
                      input logic pulse, input logic hs, input logic [2:0] st, input logic go);
    expect_out(name, p, kb, pulse, hs, st, go);
    drive(d, h, k, t);
    check_out();
  endtask

  // Reset held with hostile inputs: reset must win.
  task automatic do_reset();
    reset = 1'b1;
    step("reset_state", 32'd7, 1'b1, 1'b1, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 3'd3, 1'b0);
    reset = 1'b0;
  endtask

  // One accepted hit from ARMED, then run out hitstun and release back to ARMED.
  task automatic land_hit(input logic [31:0] d, input logic [31:0] p, input logic [31:0] kb,
                          input logic [2:0] st);
    step("land_hit", d, 1'b1, 1'b0, 1'b0, p, kb, 1'b1, 1'b1, st, 1'b0);
    repeat (20) drive(32'd0, 1'b0, 1'b0, 1'b1);
    step("land_release", 32'd0, 1'b0, 1'b0, 1'b0, p, kb, 1'b0, 1'b0, st, 1'b0);
  endtask

  // Respawn window right after a KO: 119 ticks keep hitstun, the 120th ends it.
  task automatic respawn_wait(input logic [2:0] st, input logic ko_hold);
    repeat (118) drive(32'd5, 1'b1, ko_hold, 1'b1);
    step("respawn_hold", 32'd5, 1'b1, ko_hold, 1'b1, 32'd0, 32'd0, 1'b0, 1'b1, st, 1'b0);
    step("respawn_done", 32'd0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, st, 1'b0);
  endtask

  initial begin
    vecs[0] = '{"accept_5",        32'd5,  1'b1, 1'b0, 1'b0, 32'd5, 32'd11, 1'b1, 1'b1, 3'd3, 1'b0};
    vecs[1] = '{"hitstun_idle",    32'd0,  1'b0, 1'b0, 1'b0, 32'd5, 32'd11, 1'b0, 1'b1, 3'd3, 1'b0};
    vecs[2] = '{"hitstun_ignore",  32'd9,  1'b1, 1'b0, 1'b1, 32'd5, 32'd11, 1'b0, 1'b1, 3'd3, 1'b0};
    vecs[3] = '{"ko_in_hitstun",   32'd10, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0,  1'b0, 1'b1, 3'd2, 1'b0};
    vecs[4] = '{"ko_held_respawn", 32'd10, 1'b1, 1'b1, 1'b1, 32'd0, 32'd0,  1'b0, 1'b1, 3'd2, 1'b0};

    bus.damage = 32'd0; bus.hit = 1'b0; bus.ko = 1'b0; bus.frame_tick = 1'b0;
    repeat (2) drive(32'd0, 1'b0, 1'b0, 1'b0);
    do_reset();

    // Table-driven basics: first hit, ignored hits, KO overriding a hit.
    for (int i = 0; i < 5; i++) begin
      step(vecs[i].name, vecs[i].d, vecs[i].h, vecs[i].k, vecs[i].t, vecs[i].p, vecs[i].kb,
           vecs[i].pulse, vecs[i].hs, vecs[i].st, vecs[i].go);
    end
    do_reset();

    // Held attack with a tick every cycle: one accept, hitstun ends after 20 ticks.
    for (int i = 0; i < 30; i++) begin
      step("held_attack", 32'd20, 1'b1, 1'b0, 1'b1, 32'd20, 32'd58, (i == 0), (i < 20),
           3'd3, 1'b0);
    end
    step("release", 32'd0, 1'b0, 1'b0, 1'b0, 32'd20, 32'd58, 1'b0, 1'b0, 3'd3, 1'b0);
    step("rearm_hit", 32'd10, 1'b1, 1'b0, 1'b0, 32'd30, 32'd45, 1'b1, 1'b1, 3'd3, 1'b0);
    do_reset();

    // Clamp and saturation.
    land_hit(32'h0000_0400, 32'd255, 32'd8136, 3'd3);
    land_hit(32'd255,       32'd510, 32'd16264, 3'd3);
    land_hit(32'hFFFF_FFFF, 32'd765, 32'd24392, 3'd3);
    land_hit(32'd230,       32'd995, 32'd28614, 3'd3);
    land_hit(32'd30,        32'd999, 32'd3754, 3'd3);
    land_hit(32'd15,        32'd999, 32'd1881, 3'd3);
    do_reset();

    // Stocks: KO with a simultaneous hit, ko held through respawn.
    land_hit(32'd50, 32'd50, 32'd320, 3'd3);
    step("hit_and_ko", 32'd10, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 3'd2, 1'b0);
    respawn_wait(3'd2, 1'b1);
    step("hit4", 32'd4, 1'b1, 1'b0, 1'b0, 32'd4, 32'd10, 1'b1, 1'b1, 3'd2, 1'b0);
    step("ko_tick_hitstun", 32'd0, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 1'b0, 1'b1, 3'd1, 1'b0);
    respawn_wait(3'd1, 1'b0);
    step("ko_final", 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step("dead_ignore", 32'(i * 7 + 1), 1'b1, i[0], 1'b1, 32'd0, 32'd0, 1'b0, 1'b0,
           3'd0, 1'b1);
    end
    do_reset();
    step("post_reset_hit", 32'd5, 1'b1, 1'b0, 1'b0, 32'd5, 32'd11, 1'b1, 1'b1, 3'd3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
